// File: rtl/openhw_ebu_pkg.sv
// Shared definitions for the two-manager AHB external bus arbiter.
// Holds the arbiter state encoding, the data-phase owner encoding, the AHB
// HTRANS and HBURST encodings, and the burst length decode helper.
// Optional feature macro used by the arbiter: EBU_ARB_ROUNDROBIN_EN.
package openhw_ebu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  // Beats remaining after the NONSEQ beat; any encoding other than the
  // fixed-length incrementing bursts is handled as a single transfer.
  function automatic logic [3:0] burst_beats_left(input logic [2:0] hburst);
    case (hburst)
      HBURST_SINGLE: return 4'd0;
      HBURST_INCR4:  return 4'd3;
      HBURST_INCR8:  return 4'd7;
      HBURST_INCR16: return 4'd15;
      default:       return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/openhw_ebu_arbpick.sv
// Winner selection between manager 0 (LSU) and manager 1 (IFU) at the
// arbitration point.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   req0/req1 - manager is presenting NONSEQ this cycle
//   accept    - the winner's NONSEQ is accepted at the arbitration point
//   pick_m1   - winner is manager 1 (only meaningful while any_req is set)
//   any_req   - at least one manager is requesting
// Macro EBU_ARB_ROUNDROBIN_EN: when defined, ties go to the manager that did
// not win last time; otherwise manager 0 always wins a tie.
module openhw_ebu_arbpick (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic accept,
  output logic pick_m1,
  output logic any_req
);

  assign any_req = req0 | req1;

`ifdef EBU_ARB_ROUNDROBIN_EN
  // 1 = manager 1 won last; reset to manager 1 so manager 0 takes the first tie.
  logic last_winner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_winner <= 1'b1;
    end else if (accept) begin
      last_winner <= pick_m1;
    end
  end

  always_comb begin
    pick_m1 = req1 & ~req0;
    if (req0 && req1) begin
      pick_m1 = ~last_winner;
    end
  end
`else
  logic unused_ports;
  assign unused_ports = clk ^ rst ^ accept;

  assign pick_m1 = req1 & ~req0;
`endif

endmodule

// File: rtl/openhw_ebu_arbiter.sv
// Two-manager AHB arbiter: manager 0 (LSU) and manager 1 (IFU) share one
// subordinate bus. Arbitration happens in IDLE with zero added latency; a
// fixed-length burst locks the bus to its manager until its last SEQ is
// accepted or the manager terminates early.
// Ports:
//   HCLK, HRESET            - clock, asynchronous active-high reset
//   M0H*/M1H* (inputs)      - per-manager address, control and write data
//   M0HREADY/M1HREADY       - per-manager ready (0 stalls a losing manager)
//   HTRANS..HWSTRB          - muxed subordinate-side bus
//   HREADY                  - subordinate ready
//   Grant                   - one-hot address-phase owner, 00 when idle
// Macro EBU_ARB_ROUNDROBIN_EN selects round-robin tie breaking.
module openhw_ebu_arbiter #(
  parameter int PA_BITS = 32,
  parameter int AHBW    = 64
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic [1:0]          M0HTRANS,
  input  logic [1:0]          M1HTRANS,
  input  logic [2:0]          M0HBURST,
  input  logic [2:0]          M1HBURST,
  input  logic [PA_BITS-1:0]  M0HADDR,
  input  logic [PA_BITS-1:0]  M1HADDR,
  input  logic                M0HWRITE,
  input  logic                M1HWRITE,
  input  logic [2:0]          M0HSIZE,
  input  logic [2:0]          M1HSIZE,
  input  logic [AHBW-1:0]     M0HWDATA,
  input  logic [AHBW-1:0]     M1HWDATA,
  input  logic [AHBW/8-1:0]   M0HWSTRB,
  input  logic [AHBW/8-1:0]   M1HWSTRB,
  output logic                M0HREADY,
  output logic                M1HREADY,
  output logic [1:0]          HTRANS,
  output logic [2:0]          HBURST,
  output logic [PA_BITS-1:0]  HADDR,
  output logic                HWRITE,
  output logic [2:0]          HSIZE,
  output logic [AHBW-1:0]     HWDATA,
  output logic [AHBW/8-1:0]   HWSTRB,
  input  logic                HREADY,
  output logic [1:0]          Grant
);

  import openhw_ebu_pkg::*;

  arb_state_t state, state_nxt;
  owner_t     data_owner, data_owner_nxt;
  logic [3:0] beats_left, beats_left_nxt;
  logic       pick_m1, any_req, arb_accept;
  logic       sel_m1;
  logic [1:0] grant_int, trans_out, mgr_trans;

  openhw_ebu_arbpick u_arbpick (
    .clk     (HCLK),
    .rst     (HRESET),
    .req0    (M0HTRANS == HTRANS_NONSEQ),
    .req1    (M1HTRANS == HTRANS_NONSEQ),
    .accept  (arb_accept),
    .pick_m1 (pick_m1),
    .any_req (any_req)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= ST_IDLE;
      beats_left <= 4'd0;
      data_owner <= OWN_NONE;
    end else begin
      state      <= state_nxt;
      beats_left <= beats_left_nxt;
      data_owner <= data_owner_nxt;
    end
  end

  // Grant and the address mux depend only on state and HTRANS, never on
  // HREADY; HREADY only qualifies the state/counter updates.
  always_comb begin
    sel_m1         = 1'b0;
    grant_int      = 2'b00;
    trans_out      = HTRANS_IDLE;
    arb_accept     = 1'b0;
    state_nxt      = state;
    beats_left_nxt = beats_left;
    mgr_trans      = (state == ST_BUSY1) ? M1HTRANS : M0HTRANS;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          sel_m1    = pick_m1;
          grant_int = pick_m1 ? 2'b10 : 2'b01;
          trans_out = HTRANS_NONSEQ;
          if (HREADY) begin
            arb_accept     = 1'b1;
            beats_left_nxt = burst_beats_left(pick_m1 ? M1HBURST : M0HBURST);
            if (beats_left_nxt != 4'd0) begin
              state_nxt = pick_m1 ? ST_BUSY1 : ST_BUSY0;
            end
          end
        end
      end
      ST_BUSY0, ST_BUSY1: begin
        sel_m1    = (state == ST_BUSY1);
        grant_int = sel_m1 ? 2'b10 : 2'b01;
        trans_out = mgr_trans;
        case (mgr_trans)
          HTRANS_SEQ: begin
            if (HREADY) begin
              beats_left_nxt = beats_left - 4'd1;
              if (beats_left == 4'd1) begin
                state_nxt = ST_IDLE;
              end
            end
          end
          HTRANS_BUSY: begin
          end
          // IDLE or NONSEQ from the lock holder ends the burst early.
          default: begin
            beats_left_nxt = 4'd0;
            state_nxt      = ST_IDLE;
          end
        endcase
      end
      default: begin
        state_nxt      = ST_IDLE;
        beats_left_nxt = 4'd0;
      end
    endcase
  end

  always_comb begin
    data_owner_nxt = data_owner;
    if (HREADY) begin
      if (trans_out[1]) begin
        data_owner_nxt = sel_m1 ? OWN_M1 : OWN_M0;
      end else begin
        data_owner_nxt = OWN_NONE;
      end
    end
  end

  always_comb begin
    HWDATA = '0;
    HWSTRB = '0;
    case (data_owner)
      OWN_M0: begin
        HWDATA = M0HWDATA;
        HWSTRB = M0HWSTRB;
      end
      OWN_M1: begin
        HWDATA = M1HWDATA;
        HWSTRB = M1HWSTRB;
      end
      default: begin
      end
    endcase
  end

  // Reset gates the bus directly so it goes quiet without waiting for a clock.
  assign HTRANS = HRESET ? HTRANS_IDLE : trans_out;
  assign Grant  = HRESET ? 2'b00 : grant_int;
  assign HBURST = sel_m1 ? M1HBURST : M0HBURST;
  assign HADDR  = sel_m1 ? M1HADDR  : M0HADDR;
  assign HWRITE = sel_m1 ? M1HWRITE : M0HWRITE;
  assign HSIZE  = sel_m1 ? M1HSIZE  : M0HSIZE;

  // A manager that is neither address owner nor data owner but is requesting
  // sees HREADY low, so it keeps its request on its bus.
  assign M0HREADY = HREADY & (HRESET | grant_int[0] | (data_owner == OWN_M0) | ~M0HTRANS[1]);
  assign M1HREADY = HREADY & (HRESET | grant_int[1] | (data_owner == OWN_M1) | ~M1HTRANS[1]);

endmodule

// File: tb/tb_openhw_ebu_arbiter.sv
// Self-checking bench for openhw_ebu_arbiter: directed scenarios plus a
// randomized phase, all compared against a bus-ownership model.
// Honours macro EBU_ARB_ROUNDROBIN_EN for the tie-breaking expectation.
module tb_openhw_ebu_arbiter;

  localparam int PA_BITS = 32;
  localparam int AHBW    = 64;
`ifdef EBU_ARB_ROUNDROBIN_EN
  localparam bit RR_ON = 1'b1;
`else
  localparam bit RR_ON = 1'b0;
`endif

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000, B_INCR4 = 3'b011, B_INCR8 = 3'b101, B_INCR16 = 3'b111;

  logic HCLK = 1'b0;
  logic HRESET;
  logic [1:0] M0HTRANS, M1HTRANS;
  logic [2:0] M0HBURST, M1HBURST;
  logic [PA_BITS-1:0] M0HADDR, M1HADDR;
  logic M0HWRITE, M1HWRITE;
  logic [2:0] M0HSIZE, M1HSIZE;
  logic [AHBW-1:0] M0HWDATA, M1HWDATA;
  logic [AHBW/8-1:0] M0HWSTRB, M1HWSTRB;
  logic M0HREADY, M1HREADY;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic [PA_BITS-1:0] HADDR;
  logic HWRITE;
  logic [2:0] HSIZE;
  logic [AHBW-1:0] HWDATA;
  logic [AHBW/8-1:0] HWSTRB;
  logic HREADY;
  logic [1:0] Grant;

  openhw_ebu_arbiter #(.PA_BITS(PA_BITS), .AHBW(AHBW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0HTRANS(M0HTRANS), .M1HTRANS(M1HTRANS),
    .M0HBURST(M0HBURST), .M1HBURST(M1HBURST),
    .M0HADDR(M0HADDR), .M1HADDR(M1HADDR),
    .M0HWRITE(M0HWRITE), .M1HWRITE(M1HWRITE),
    .M0HSIZE(M0HSIZE), .M1HSIZE(M1HSIZE),
    .M0HWDATA(M0HWDATA), .M1HWDATA(M1HWDATA),
    .M0HWSTRB(M0HWSTRB), .M1HWSTRB(M1HWSTRB),
    .M0HREADY(M0HREADY), .M1HREADY(M1HREADY),
    .HTRANS(HTRANS), .HBURST(HBURST), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
    .HREADY(HREADY), .Grant(Grant)
  );

  always #5 HCLK = ~HCLK;

  int nChecks = 0;
  int nFails  = 0;

  // Ownership model: which manager holds a burst lock and how many SEQ beats
  // it still owes, which manager owns the data phase, and who won last.
  int lockOwner = -1;
  int beatsOwed = 0;
  int dataMgr   = -1;
  int lastWin   = 1;

  int addrMgr;
  logic [1:0] expGrant, expTrans;
  logic [2:0] expBurst, expSize;
  logic [PA_BITS-1:0] expAddr;
  logic expWrite, expRdy0, expRdy1;
  logic [AHBW-1:0] expWdata;
  logic [AHBW/8-1:0] expStrb;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int burstLength(input logic [2:0] b);
    case (b)
      3'b011:  return 4;
      3'b101:  return 8;
      3'b111:  return 16;
      default: return 1;
    endcase
  endfunction

  task automatic predict();
    logic [1:0] tr [2];
    bit want0, want1;
    int fieldMgr;
    tr[0] = M0HTRANS;
    tr[1] = M1HTRANS;
    addrMgr = -1;
    if (lockOwner >= 0) begin
      addrMgr  = lockOwner;
      expTrans = tr[lockOwner];
    end else begin
      want0 = (tr[0] == T_NS);
      want1 = (tr[1] == T_NS);
      if (want0 && want1) addrMgr = RR_ON ? (1 - lastWin) : 0;
      else if (want0) addrMgr = 0;
      else if (want1) addrMgr = 1;
      expTrans = (addrMgr >= 0) ? T_NS : T_IDLE;
    end
    fieldMgr = (addrMgr == 1) ? 1 : 0;
    expGrant = (addrMgr == 0) ? 2'b01 : (addrMgr == 1) ? 2'b10 : 2'b00;
    expAddr  = fieldMgr ? M1HADDR  : M0HADDR;
    expBurst = fieldMgr ? M1HBURST : M0HBURST;
    expWrite = fieldMgr ? M1HWRITE : M0HWRITE;
    expSize  = fieldMgr ? M1HSIZE  : M0HSIZE;
    expWdata = (dataMgr == 0) ? M0HWDATA : (dataMgr == 1) ? M1HWDATA : '0;
    expStrb  = (dataMgr == 0) ? M0HWSTRB : (dataMgr == 1) ? M1HWSTRB : '0;
    expRdy0  = HREADY && (addrMgr == 0 || dataMgr == 0 || !tr[0][1]);
    expRdy1  = HREADY && (addrMgr == 1 || dataMgr == 1 || !tr[1][1]);
  endtask

  task automatic advanceModel();
    logic [1:0] tr [2];
    logic [2:0] bu [2];
    tr[0] = M0HTRANS; tr[1] = M1HTRANS;
    bu[0] = M0HBURST; bu[1] = M1HBURST;
    if (HREADY) dataMgr = expTrans[1] ? addrMgr : -1;
    if (lockOwner < 0) begin
      if (addrMgr >= 0 && HREADY) begin
        lastWin = addrMgr;
        if (burstLength(bu[addrMgr]) > 1) begin
          lockOwner = addrMgr;
          beatsOwed = burstLength(bu[addrMgr]) - 1;
        end
      end
    end else begin
      case (tr[lockOwner])
        T_SEQ: if (HREADY) begin
          beatsOwed--;
          if (beatsOwed == 0) lockOwner = -1;
        end
        T_BUSY: ;
        default: begin
          lockOwner = -1;
          beatsOwed = 0;
        end
      endcase
    end
  endtask

  task automatic compareAll();
    checkOutput("grant",  64'(Grant),    64'(expGrant));
    checkOutput("htrans", 64'(HTRANS),   64'(expTrans));
    checkOutput("haddr",  64'(HADDR),    64'(expAddr));
    checkOutput("hburst", 64'(HBURST),   64'(expBurst));
    checkOutput("hwrite", 64'(HWRITE),   64'(expWrite));
    checkOutput("hsize",  64'(HSIZE),    64'(expSize));
    checkOutput("hwdata", 64'(HWDATA),   64'(expWdata));
    checkOutput("hwstrb", 64'(HWSTRB),   64'(expStrb));
    checkOutput("m0ready", 64'(M0HREADY), 64'(expRdy0));
    checkOutput("m1ready", 64'(M1HREADY), 64'(expRdy1));
  endtask

  // One bus cycle: drive at the falling edge, check 1 ns later, then step the model.
  task automatic applyStimulus(input logic [1:0] t0, input logic [2:0] b0, input logic [31:0] a0,
                               input logic [1:0] t1, input logic [2:0] b1, input logic [31:0] a1,
                               input logic rdy);
    @(negedge HCLK);
    M0HTRANS = t0; M0HBURST = b0; M0HADDR = a0;
    M1HTRANS = t1; M1HBURST = b1; M1HADDR = a1;
    M0HWRITE = 1'($urandom); M1HWRITE = 1'($urandom);
    M0HSIZE  = 3'($urandom); M1HSIZE  = 3'($urandom);
    M0HWDATA = {$urandom, $urandom}; M1HWDATA = {$urandom, $urandom};
    M0HWSTRB = 8'($urandom); M1HWSTRB = 8'($urandom);
    HREADY = rdy;
    #1;
    predict();
    compareAll();
    advanceModel();
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_htrans"}, 64'(HTRANS), 64'd0);
    checkOutput({tag, "_grant"},  64'(Grant),  64'd0);
    checkOutput({tag, "_hwdata"}, 64'(HWDATA), 64'd0);
    checkOutput({tag, "_m0ready"}, 64'(M0HREADY), 64'(HREADY));
    checkOutput({tag, "_m1ready"}, 64'(M1HREADY), 64'(HREADY));
  endtask

  task automatic drain();
    applyStimulus(T_IDLE, B_SINGLE, 32'h0, T_IDLE, B_SINGLE, 32'h0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0] t [2];
    logic [2:0] b [2];
    int r;
    logic [1:0] expG;

    HRESET = 1'b1; HREADY = 1'b1;
    M0HTRANS = T_NS; M1HTRANS = T_NS; M0HBURST = B_INCR4; M1HBURST = B_SINGLE;
    M0HADDR = 32'h0; M1HADDR = 32'h0; M0HWRITE = 1'b0; M1HWRITE = 1'b0;
    M0HSIZE = 3'd3; M1HSIZE = 3'd3; M0HWDATA = 64'h1111_2222_3333_4444;
    M1HWDATA = 64'h5555_6666_7777_8888; M0HWSTRB = 8'hFF; M1HWSTRB = 8'hFF;
    #2 checkReset("reset_rdy1");
    HREADY = 1'b0;
    #1 checkReset("reset_rdy0");
    @(posedge HCLK); #1 HRESET = 1'b0;

    // M0 single read alone, then M1 alone shows no lock was taken.
    applyStimulus(T_NS, B_SINGLE, 32'h8000_0000, T_IDLE, B_SINGLE, 32'h1000, 1'b1);
    checkOutput("single_grant", 64'(Grant), 64'd1);
    checkOutput("single_haddr", 64'(HADDR), 64'h8000_0000);
    checkOutput("single_m1ready", 64'(M1HREADY), 64'd1);
    applyStimulus(T_IDLE, B_SINGLE, 32'h0, T_NS, B_SINGLE, 32'h1000, 1'b1);
    checkOutput("single_stays_idle", 64'(Grant), 64'd2);
    drain();

    // M0 INCR4 against a simultaneous M1 request.
    applyStimulus(T_NS, B_INCR4, 32'h100, T_NS, B_SINGLE, 32'h2000, 1'b1);
    checkOutput("incr4_grant", 64'(Grant), 64'd1);
    checkOutput("incr4_m1stall", 64'(M1HREADY), 64'd0);
    for (int k = 1; k < 4; k++) begin
      applyStimulus(T_SEQ, B_INCR4, 32'(32'h100 + 8 * k), T_NS, B_SINGLE, 32'h2000, 1'b1);
      checkOutput("incr4_grant", 64'(Grant), 64'd1);
      checkOutput("incr4_m1stall", 64'(M1HREADY), 64'd0);
    end
    applyStimulus(T_IDLE, B_SINGLE, 32'h0, T_NS, B_SINGLE, 32'h2000, 1'b1);
    checkOutput("incr4_m1_grant", 64'(Grant), 64'd2);
    checkOutput("incr4_m1_trans", 64'(HTRANS), 64'(T_NS));
    checkOutput("incr4_m1_addr", 64'(HADDR), 64'h2000);
    drain();

    // M0 INCR8 with a 3-cycle wait state at beat 4; M1 waits throughout.
    applyStimulus(T_NS, B_INCR8, 32'h4000, T_NS, B_SINGLE, 32'h5000, 1'b1);
    checkOutput("incr8_grant", 64'(Grant), 64'd1);
    for (int beat = 2; beat <= 8; beat++) begin
      if (beat == 4) begin
        for (int w = 0; w < 3; w++) begin
          applyStimulus(T_SEQ, B_INCR8, 32'h4018, T_NS, B_SINGLE, 32'h5000, 1'b0);
          checkOutput("incr8_wait_haddr", 64'(HADDR), 64'h4018);
          checkOutput("incr8_wait_grant", 64'(Grant), 64'd1);
        end
      end
      applyStimulus(T_SEQ, B_INCR8, 32'(32'h4000 + 8 * (beat - 1)), T_NS, B_SINGLE, 32'h5000, 1'b1);
      checkOutput("incr8_grant", 64'(Grant), 64'd1);
    end
    applyStimulus(T_IDLE, B_SINGLE, 32'h0, T_NS, B_SINGLE, 32'h5000, 1'b1);
    checkOutput("incr8_then_idle", 64'(Grant), 64'd2);
    drain();

    // M1 INCR4 aborted with IDLE after two beats; M0 is waiting.
    applyStimulus(T_IDLE, B_SINGLE, 32'h0, T_NS, B_INCR4, 32'h6000, 1'b1);
    checkOutput("abort_grant", 64'(Grant), 64'd2);
    applyStimulus(T_NS, B_SINGLE, 32'h7000, T_SEQ, B_INCR4, 32'h6008, 1'b1);
    checkOutput("abort_m0stall", 64'(M0HREADY), 64'd0);
    applyStimulus(T_NS, B_SINGLE, 32'h7000, T_IDLE, B_INCR4, 32'h0, 1'b1);
    checkOutput("abort_trans", 64'(HTRANS), 64'(T_IDLE));
    checkOutput("abort_m0stall2", 64'(M0HREADY), 64'd0);
    applyStimulus(T_NS, B_SINGLE, 32'h7000, T_IDLE, B_SINGLE, 32'h0, 1'b1);
    checkOutput("abort_m0_grant", 64'(Grant), 64'd1);
    checkOutput("abort_m0_addr", 64'(HADDR), 64'h7000);
    drain();

    // Continuous singles from both managers after M1 won last.
    applyStimulus(T_IDLE, B_SINGLE, 32'h0, T_NS, B_SINGLE, 32'h9000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(T_NS, B_SINGLE, 32'h8000, T_NS, B_SINGLE, 32'h9000, 1'b1);
      expG = (RR_ON && (k % 2 == 1)) ? 2'b10 : 2'b01;
      checkOutput("tie_grant", 64'(Grant), 64'(expG));
    end
    drain();

    // Randomized traffic; managers mostly continue bursts they hold.
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        r = int'($urandom_range(0, 99));
        if (lockOwner == m)
          t[m] = (r < 70) ? T_SEQ : (r < 85) ? T_BUSY : (r < 93) ? T_IDLE : T_NS;
        else
          t[m] = (r < 55) ? T_NS : (r < 90) ? T_IDLE : (r < 95) ? T_BUSY : T_SEQ;
        b[m] = 3'($urandom_range(0, 7));
      end
      applyStimulus(t[0], b[0], $urandom, t[1], b[1], $urandom, 1'($urandom_range(0, 3) != 0));
    end
    drain();

    // Reset pulsed during beat 5 of an M0 INCR16.
    applyStimulus(T_NS, B_INCR16, 32'hA000, T_IDLE, B_SINGLE, 32'h0, 1'b1);
    for (int beat = 2; beat <= 4; beat++)
      applyStimulus(T_SEQ, B_INCR16, 32'(32'hA000 + 8 * (beat - 1)), T_IDLE, B_SINGLE, 32'h0, 1'b1);
    @(negedge HCLK);
    M0HTRANS = T_SEQ; M0HADDR = 32'hA020; M0HWDATA = 64'hDEAD_BEEF_0123_4567;
    M1HTRANS = T_NS; HREADY = 1'b1;
    #1;
    checkOutput("rst_mid_pre_grant", 64'(Grant), 64'd1);
    checkOutput("rst_mid_pre_trans", 64'(HTRANS), 64'(T_SEQ));
    checkOutput("rst_mid_pre_wdata", 64'(HWDATA), 64'hDEAD_BEEF_0123_4567);
    #1 HRESET = 1'b1;
    #1 checkReset("rst_mid");
    lockOwner = -1; beatsOwed = 0; dataMgr = -1; lastWin = 1;
    @(posedge HCLK); #1 HRESET = 1'b0;
    applyStimulus(T_SEQ, B_INCR16, 32'hA028, T_IDLE, B_SINGLE, 32'h0, 1'b1);
    checkOutput("rst_no_resume_trans", 64'(HTRANS), 64'(T_IDLE));
    checkOutput("rst_no_resume_grant", 64'(Grant), 64'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
